// File: rtl/tanimoto_result_collector_if.sv
// rtl/tanimoto_result_collector_if.sv - result/hit stream bundle between comparator, collector and hit sink
//
// Purpose : groups the comparator result stream, the hit output stream and
//           the collector status outputs into one bundle.
// Modports:
//   slave  - the collector: consumes i_Valid/i_Dout/i_Last/i_HitReady,
//            drives i_Ready, o_HitValid, o_HitIdx, o_HitCount, o_Overflow, o_Done
//   master - the environment (comparator + hit sink): the opposite directions
interface tanimoto_result_collector_if #(
  parameter int IDX_WIDTH = 16
);
  logic                 i_Valid;
  logic                 i_Dout;
  logic                 i_Last;
  logic                 i_Ready;
  logic                 o_HitValid;
  logic [IDX_WIDTH-1:0] o_HitIdx;
  logic                 i_HitReady;
  logic [IDX_WIDTH-1:0] o_HitCount;
  logic                 o_Overflow;
  logic                 o_Done;

  modport slave (
    input  i_Valid, i_Dout, i_Last, i_HitReady,
    output i_Ready, o_HitValid, o_HitIdx, o_HitCount, o_Overflow, o_Done
  );

  modport master (
    output i_Valid, i_Dout, i_Last, i_HitReady,
    input  i_Ready, o_HitValid, o_HitIdx, o_HitCount, o_Overflow, o_Done
  );
endinterface

// File: rtl/tanimoto_result_collector.sv
// rtl/tanimoto_result_collector.sv - numbers comparator results and buffers hit indices in a FWFT FIFO
//
// Purpose : accepts Tanimoto comparator results, assigns each a running pair
//           index, queues indices of hits, streams them out, and tracks
//           batch boundaries, hit totals and lost results.
// Ports   :
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - tanimoto_result_collector_if.slave (result stream in, hit stream
//          out, i_Ready backpressure, o_HitCount, o_Overflow, o_Done)
module tanimoto_result_collector #(
  parameter int IDX_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SKID       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  tanimoto_result_collector_if.slave     bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SKID_C  = CW'(SKID);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;

  logic                 not_empty;
  logic                 pop;
  logic                 push;
  logic                 accept;
  logic                 run_ok;
  logic [CW-1:0]        free_after_pop;
  logic [CW-1:0]        free_next;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & bus.i_HitReady;
  assign run_ok    = (state_q == IDLE) || (state_q == RUN);

  // A same-cycle pop frees its slot before the accept decision, so a full
  // FIFO that is being drained still takes the incoming result.
  assign free_after_pop = DEPTH_C - count_q + {{AW{1'b0}}, pop};
  assign accept         = bus.i_Valid & run_ok & (free_after_pop != '0);
  assign push           = accept & bus.i_Dout;

  always_comb begin
    count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    free_next = DEPTH_C - count_d;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d     = ovf_q | (bus.i_Valid & ~accept);
    state_d   = state_q;
    idx_d     = idx_q;
    hit_cnt_d = hit_cnt_q;

    // Index advances on every valid result in IDLE/RUN, dropped ones included,
    // so later indices stay aligned with pair order.
    if (bus.i_Valid && run_ok) begin
      idx_d = idx_q + 1'b1;
    end

    // The first accepted result of a batch restarts the hit total.
    if (accept && state_q == IDLE) begin
      hit_cnt_d = {{(IDX_WIDTH-1){1'b0}}, push};
    end else if (push && hit_cnt_q != '1) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (bus.i_Last) begin
            state_d = (count_d == '0) ? DONE : DRAIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      DRAIN: begin
        if (!not_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    ready_d = ((state_d == IDLE) || (state_d == RUN)) && (free_next > SKID_C);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      hit_cnt_q <= hit_cnt_d;
      ovf_q     <= ovf_d;
      ready_q   <= ready_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= idx_q;
    end
  end

  assign bus.i_Ready    = ready_q;
  assign bus.o_HitValid = not_empty;
  assign bus.o_HitIdx   = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.o_HitCount = hit_cnt_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Done     = (state_q == DONE);

endmodule

// File: tb/tb_tanimoto_result_collector.sv
// tb/tb_tanimoto_result_collector.sv - directed self-checking bench for tanimoto_result_collector
module tb_tanimoto_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tanimoto_result_collector_if #(.IDX_WIDTH(16)) ifa ();
  tanimoto_result_collector_if #(.IDX_WIDTH(4))  ifb ();

  tanimoto_result_collector #(.IDX_WIDTH(16), .FIFO_DEPTH(16), .SKID(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  tanimoto_result_collector #(.IDX_WIDTH(4), .FIFO_DEPTH(16), .SKID(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int checks = 0;
  int errors = 0;

  int got_idx[$];
  int got_hc[$];
  int done_cnt = 0;

  // Inputs change only at posedge+1, so negedge values are the ones the
  // next posedge will act on.
  always @(negedge clk) begin
    if (rst && ifa.o_HitValid && ifa.i_HitReady) got_idx.push_back(int'(ifa.o_HitIdx));
    if (rst && ifa.o_Done) begin
      done_cnt = done_cnt + 1;
      got_hc.push_back(int'(ifa.o_HitCount));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.i_Valid = 1'b0; ifa.i_Dout = 1'b0; ifa.i_Last = 1'b0; ifa.i_HitReady = 1'b0;
    ifb.i_Valid = 1'b0; ifb.i_Dout = 1'b0; ifb.i_Last = 1'b0; ifb.i_HitReady = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drive_a(input logic dout, input logic last);
    ifa.i_Valid = 1'b1; ifa.i_Dout = dout; ifa.i_Last = last;
    tick();
    ifa.i_Valid = 1'b0; ifa.i_Dout = 1'b0; ifa.i_Last = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 100; n++) begin
      if (done_cnt >= target) break;
      tick();
    end
    check("done_seen", done_cnt, target);
  endtask

  initial begin
    int base;
    int dbase;
    logic [7:0] pat;
    int exp1 [4];
    exp1 = '{0, 2, 5, 6};

    idle_inputs();
    rst = 1'b0;
    tick();
    check("rst_hitvalid", ifa.o_HitValid, 0);
    check("rst_ready",    ifa.i_Ready,    1);
    check("rst_hitcount", ifa.o_HitCount, 0);
    check("rst_overflow", ifa.o_Overflow, 0);
    check("rst_done",     ifa.o_Done,     0);
    check("rst_hitidx",   ifa.o_HitIdx,   0);
    tick();
    rst = 1'b1;

    // 1: mixed batch with free-flowing output
    base = got_idx.size(); dbase = done_cnt;
    pat = 8'b0110_0101;
    ifa.i_HitReady = 1'b1;
    for (int i = 0; i < 8; i++) drive_a(pat[i], i == 7);
    wait_done(dbase + 1);
    for (int i = 0; i < 5; i++) tick();
    check("t1_nhits", got_idx.size() - base, 4);
    for (int i = 0; i < 4; i++) check("t1_idx", got_idx[base + i], exp1[i]);
    check("t1_hc_at_done", got_hc[got_hc.size() - 1], 4);
    check("t1_done_once", done_cnt - dbase, 1);
    check("t1_overflow", ifa.o_Overflow, 0);

    // 2: fill past capacity with output stalled
    do_reset();
    base = got_idx.size();
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b1, 1'b0);
      if (k == 12) check("t2_ready_occ13", ifa.i_Ready, 1);
      if (k == 13) check("t2_ready_occ14", ifa.i_Ready, 0);
    end
    check("t2_overflow", ifa.o_Overflow, 1);
    check("t2_head", ifa.o_HitIdx, 0);
    tick(); tick();
    check("t2_head_stable", ifa.o_HitIdx, 0);
    check("t2_hitcount", ifa.o_HitCount, 16);
    ifa.i_HitReady = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("t2_nhits", got_idx.size() - base, 16);
    for (int i = 0; i < 16; i++) check("t2_idx", got_idx[base + i], i);
    check("t2_overflow_sticky", ifa.o_Overflow, 1);
    check("t2_empty", ifa.o_HitValid, 0);

    // 3: push and pop on a full FIFO
    do_reset();
    base = got_idx.size();
    for (int k = 0; k < 16; k++) drive_a(1'b1, 1'b0);
    check("t3_full_ready", ifa.i_Ready, 0);
    check("t3_full_ovf", ifa.o_Overflow, 0);
    ifa.i_HitReady = 1'b1;
    drive_a(1'b1, 1'b0);
    ifa.i_HitReady = 1'b0;
    check("t3_ovf", ifa.o_Overflow, 0);
    check("t3_head", ifa.o_HitIdx, 1);
    check("t3_hitcount", ifa.o_HitCount, 17);
    ifa.i_HitReady = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("t3_nhits", got_idx.size() - base, 17);
    for (int i = 0; i < 17; i++) check("t3_idx", got_idx[base + i], i);

    // 4: two back-to-back batches
    do_reset();
    base = got_idx.size(); dbase = done_cnt;
    ifa.i_HitReady = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) drive_a(1'b1, i == 2);
      wait_done(dbase + b + 1);
      check("t4_hc_at_done", got_hc[got_hc.size() - 1], 3);
    end
    for (int i = 0; i < 5; i++) tick();
    check("t4_done_twice", done_cnt - dbase, 2);
    check("t4_nhits", got_idx.size() - base, 6);
    for (int i = 0; i < 6; i++) check("t4_idx", got_idx[base + i], i % 3);
    check("t4_ovf", ifa.o_Overflow, 0);

    // 5: reset in the middle of a batch
    do_reset();
    for (int k = 0; k < 5; k++) drive_a(1'b1, 1'b0);
    check("t5_pre_valid", ifa.o_HitValid, 1);
    check("t5_pre_hc", ifa.o_HitCount, 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_hitvalid", ifa.o_HitValid, 0);
    check("t5_ready", ifa.i_Ready, 1);
    check("t5_hitcount", ifa.o_HitCount, 0);
    drive_a(1'b1, 1'b0);
    check("t5_new_valid", ifa.o_HitValid, 1);
    check("t5_new_idx", ifa.o_HitIdx, 0);

    // 6: 4-bit index wraps
    do_reset();
    for (int k = 0; k < 19; k++) begin
      ifb.i_Valid = 1'b1; ifb.i_Dout = (k == 18); ifb.i_Last = 1'b0;
      tick();
    end
    ifb.i_Valid = 1'b0; ifb.i_Dout = 1'b0;
    check("t6_valid", ifb.o_HitValid, 1);
    check("t6_idx", ifb.o_HitIdx, 2);
    check("t6_hitcount", ifb.o_HitCount, 1);
    check("t6_ovf", ifb.o_Overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
